// File: rtl/fast2slow_pkg.sv
// fast2slow_pkg: shared state encoding and default parameters for the fast-to-slow pulse link
package fast2slow_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_LOW} f2s_state_e;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W = 4;
  localparam int DEF_TIMEOUT = 0;
endpackage

// File: rtl/fast2slow_pulse_tx_sync_bit.sv
// sync_bit: N-stage single-bit synchronizer with synchronous reset
module sync_bit #(
  parameter int N = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic [N-1:0] sync_q;
  // shift the asynchronous input through N flops
  always_ff @(posedge clk_i)
    sync_q <= rst_i ? '0 : {sync_q[N-2:0], d_i};
  assign q_o = sync_q[N-1];
endmodule

// File: rtl/fast2slow_pulse_tx.sv
// fast2slow_pulse_tx: queues fast-domain event pulses and sends each one over a four-phase req/ack handshake
module fast2slow_pulse_tx
  import fast2slow_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             fclk,
  input  logic             reset,
  input  logic             f_pulse,
  input  logic             s_ack,
  input  logic             err_clr,
  output logic             s_req,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic             timeout_err
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  f2s_state_e state_q, state_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic ack_s, launch, from_q, queue, drop, tick, tmo_set;
  logic s_req_q, busy_q, done_q, ovf_q, tmo_q;
  sync_bit #(.N(SYNC_STAGES)) u_ack_sync (
    .clk_i(fclk),
    .rst_i(reset),
    .d_i  (s_ack),
    .q_o  (ack_s)
  );
  // launch decision, queue bookkeeping and handshake watchdog; launch waits for ack_s low so a stale ack after reset is never mistaken for a reply
  always_comb begin
    launch = state_q == IDLE && !ack_s && (f_pulse || pending_q != '0);
    state_d = launch ? REQ :
              (state_q == REQ && ack_s) ? WAIT_LOW :
              (state_q == WAIT_LOW && !ack_s) ? IDLE : state_q;
    from_q = launch && pending_q != '0;
    queue = f_pulse && !launch;
    drop = queue && pending_q == CNT_MAX;
    pending_d = (from_q && !f_pulse) ? pending_q - CNT_W'(1) :
                (queue && !drop) ? pending_q + CNT_W'(1) : pending_q;
    tick = state_q != IDLE && state_d == state_q;
    tcnt_d = !tick ? '0 : tcnt_q == TW'(TIMEOUT) ? tcnt_q : tcnt_q + TW'(1);
    tmo_set = TIMEOUT != 0 && tick && tcnt_q == TW'(TIMEOUT - 1);
  end
  // state, registered outputs and sticky error flags; a set in the same cycle as err_clr wins
  always_ff @(posedge fclk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      tcnt_q    <= '0;
      s_req_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      tcnt_q    <= tcnt_d;
      s_req_q   <= state_d == REQ;
      busy_q    <= state_d != IDLE;
      done_q    <= state_q == WAIT_LOW && state_d == IDLE;
      ovf_q     <= drop || (ovf_q && !err_clr);
      tmo_q     <= tmo_set || (tmo_q && !err_clr);
    end
  end
  assign s_req = s_req_q;
  assign busy = busy_q;
  assign done = done_q;
  assign pending = pending_q;
  assign overflow = ovf_q;
  assign timeout_err = tmo_q;
endmodule
